// File: rtl/mppt_pkg.sv
// Shared types and helpers for the MPPT PWM output stage.
// Holds duty width, default clamp limits, the dead-time FSM states
// and the duty clamp helper.
package mppt_pkg;

  localparam int DUTY_W = 16;

  localparam logic [DUTY_W-1:0] DUTY_MIN_DEF = 16'h0CCD;
  localparam logic [DUTY_W-1:0] DUTY_MAX_DEF = 16'hF333;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    DT_LH,
    HI,
    DT_HL
  } dt_state_t;

  function automatic logic [DUTY_W-1:0] clamp_duty(
    input logic [DUTY_W-1:0] d,
    input logic [DUTY_W-1:0] lo,
    input logic [DUTY_W-1:0] hi
  );
    if (d < lo) begin
      return lo;
    end else if (d > hi) begin
      return hi;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/pwm_deadtime_driver_if.sv
// Duty command handshake between the MPPT core (master) and the
// PWM driver (slave). A transfer happens on a clock edge where
// duty_valid and duty_ready are both high.
interface pwm_deadtime_driver_if;
  import mppt_pkg::*;

  logic [DUTY_W-1:0] duty_in;
  logic              duty_valid;
  logic              duty_ready;

  modport master (
    output duty_in,
    output duty_valid,
    input  duty_ready
  );

  modport slave (
    input  duty_in,
    input  duty_valid,
    output duty_ready
  );

endinterface

// File: rtl/pwm_deadtime_fsm.sv
// Dead-time FSM: turns the raw PWM comparison into a complementary
// gate-drive pair with DEADTIME cycles of both-off at each transition.
// A raw glitch inside the dead band returns to the previous side.
module pwm_deadtime_fsm
  import mppt_pkg::*;
#(
  parameter int DEADTIME = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic raw,
  output logic pwm_hi,
  output logic pwm_lo
);

  localparam int DT_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME - 1);

  dt_state_t       state;
  logic [DT_W-1:0] dt_cnt;

  // State, dead-band counter and registered gate outputs in one place
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      dt_cnt <= '0;
      pwm_hi <= 1'b0;
      pwm_lo <= 1'b0;
    end else if (!enable) begin
      state  <= IDLE;
      dt_cnt <= '0;
      pwm_hi <= 1'b0;
      pwm_lo <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state  <= LO;
          pwm_hi <= 1'b0;
          pwm_lo <= 1'b1;
        end
        LO: begin
          if (raw) begin
            state  <= DT_LH;
            dt_cnt <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
          end
        end
        DT_LH: begin
          if (!raw) begin
            state  <= LO;
            pwm_lo <= 1'b1;
          end else if (dt_cnt == DT_LAST) begin
            state  <= HI;
            pwm_hi <= 1'b1;
          end else begin
            dt_cnt <= dt_cnt + DT_W'(1);
          end
        end
        HI: begin
          if (!raw) begin
            state  <= DT_HL;
            dt_cnt <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
          end
        end
        DT_HL: begin
          if (raw) begin
            state  <= HI;
            pwm_hi <= 1'b1;
          end else if (dt_cnt == DT_LAST) begin
            state  <= LO;
            pwm_lo <= 1'b1;
          end else begin
            dt_cnt <= dt_cnt + DT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          pwm_hi <= 1'b0;
          pwm_lo <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pwm_deadtime_driver.sv
// Complementary PWM driver with dead time for the MPPT converter.
// Duty commands are clamped into a shadow register and loaded at the
// period wrap; period_start / sample_trig align upstream sampling.
// Optional soft start: define PWM_SOFTSTART_EN to ramp duty_applied
// toward the target by at most RAMP_STEP per period.
module pwm_deadtime_driver
  import mppt_pkg::*;
#(
  parameter int                CNT_W         = 10,
  parameter int                PERIOD        = 1000,
  parameter int                DEADTIME      = 8,
  parameter logic [DUTY_W-1:0] DUTY_MIN      = DUTY_MIN_DEF,
  parameter logic [DUTY_W-1:0] DUTY_MAX      = DUTY_MAX_DEF,
`ifdef PWM_SOFTSTART_EN
  parameter logic [DUTY_W-1:0] RAMP_STEP     = 16'h0100,
`endif
  parameter int                SAMPLE_OFFSET = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  pwm_deadtime_driver_if.slave    duty_bus,
  output logic                    pwm_hi,
  output logic                    pwm_lo,
  output logic                    period_start,
  output logic                    sample_trig,
  output logic [DUTY_W-1:0]       duty_applied,
  output logic                    clamp_flag
);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_OFFSET);

  function automatic logic [CNT_W-1:0] duty_to_compare(input logic [DUTY_W-1:0] d);
    logic [31:0] prod;
    prod = {16'b0, d} * 32'(PERIOD);
    return prod[16 +: CNT_W];
  endfunction

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  compare;
  logic [DUTY_W-1:0] shadow;
  logic              pending;
  logic              wrap;
  logic              transfer;
  logic              raw;
  logic              out_of_range;

  assign wrap                = enable && (cnt == CNT_LAST);
  assign transfer            = duty_bus.duty_valid && !pending;
  assign duty_bus.duty_ready = !pending;
  assign raw                 = (cnt < compare);
  assign out_of_range        = (duty_bus.duty_in < DUTY_MIN) || (duty_bus.duty_in > DUTY_MAX);

  // Period counter: runs 0..PERIOD-1 while enabled, parked at 0 otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!enable || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Registered period and sample strobes, suppressed while disabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_start <= 1'b0;
      sample_trig  <= 1'b0;
    end else begin
      period_start <= enable && (cnt == '0);
      sample_trig  <= enable && (cnt == SAMPLE_CNT);
    end
  end

  // Shadow register handshake: one command held until the next wrap consumes it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow     <= DUTY_MIN;
      pending    <= 1'b0;
      clamp_flag <= 1'b0;
    end else if (wrap && pending) begin
      pending <= 1'b0;
    end else if (transfer) begin
      shadow     <= clamp_duty(duty_bus.duty_in, DUTY_MIN, DUTY_MAX);
      pending    <= 1'b1;
      clamp_flag <= out_of_range;
    end
  end

`ifdef PWM_SOFTSTART_EN
  logic [DUTY_W-1:0] target;
  logic [DUTY_W-1:0] ramp_goal;
  logic [DUTY_W-1:0] ramp_next;
  logic              enable_d;

  assign ramp_goal = pending ? shadow : target;

  // Next ramp point: step toward the goal by at most RAMP_STEP
  always_comb begin
    ramp_next = duty_applied;
    if (duty_applied < ramp_goal) begin
      ramp_next = ((ramp_goal - duty_applied) > RAMP_STEP) ? (duty_applied + RAMP_STEP) : ramp_goal;
    end else if (duty_applied > ramp_goal) begin
      ramp_next = ((duty_applied - ramp_goal) > RAMP_STEP) ? (duty_applied - RAMP_STEP) : ramp_goal;
    end
  end

  // Applied duty ramps at each wrap and restarts from DUTY_MIN on enable rise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_applied <= DUTY_MIN;
      compare      <= duty_to_compare(DUTY_MIN);
      target       <= DUTY_MIN;
      enable_d     <= 1'b0;
    end else begin
      enable_d <= enable;
      if (enable && !enable_d) begin
        duty_applied <= DUTY_MIN;
        compare      <= duty_to_compare(DUTY_MIN);
      end else if (wrap) begin
        if (pending) begin
          target <= shadow;
        end
        duty_applied <= ramp_next;
        compare      <= duty_to_compare(ramp_next);
      end
    end
  end
`else
  // Applied duty and compare threshold jump to the shadow value at the wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_applied <= DUTY_MIN;
      compare      <= duty_to_compare(DUTY_MIN);
    end else if (wrap && pending) begin
      duty_applied <= shadow;
      compare      <= duty_to_compare(shadow);
    end
  end
`endif

  pwm_deadtime_fsm #(
    .DEADTIME (DEADTIME)
  ) u_fsm (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .raw    (raw),
    .pwm_hi (pwm_hi),
    .pwm_lo (pwm_lo)
  );

endmodule

// File: doc/pwm_deadtime_driver.md
Name: pwm_deadtime_driver

Overview:
- Downstream stage of the incremental-conductance MPPT core.
- Consumes the 16-bit duty command (unsigned fraction of full scale, 0xFFFF ≈ 100%) and drives the converter switch pair with complementary, dead-time-protected PWM.
- Emits a per-period start pulse and a mid-period sample trigger, so the upstream voltage/current sampling is aligned to the switching period.
- Duty updates are double-buffered and take effect only at a period boundary.

Parameters:
- CNT_W, 10, width of the period counter.
- PERIOD, 1000, clk cycles per PWM period; range 2..2^CNT_W.
- DEADTIME, 8, clk cycles with both switches off at each transition; must be ≥1.
- DUTY_MIN, 16'h0CCD, lower clamp (≈5%).
- DUTY_MAX, 16'hF333, upper clamp (≈95%).
- SAMPLE_OFFSET, 500, counter value at which sample_trig pulses; must be < PERIOD.
- RAMP_STEP, 16'h0100, soft-start increment per period (optional feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run the PWM; low forces both switches off.
- duty_in  in  16  duty command from the MPPT core.
- duty_valid  in  1  duty_in is valid.
- duty_ready  out  1  shadow register is free to accept a command.
- pwm_hi  out  1  high-side gate drive.
- pwm_lo  out  1  low-side gate drive.
- period_start  out  1  one-cycle pulse when cnt==0.
- sample_trig  out  1  one-cycle pulse when cnt==SAMPLE_OFFSET.
- duty_applied  out  16  duty currently in effect, after clamping.
- clamp_flag  out  1  last accepted command was clamped.

Behaviour:
- Reset (asynchronous, reset==0):
  - cnt=0, pending=0, state=IDLE.
  - pwm_hi=pwm_lo=0, period_start=sample_trig=0, clamp_flag=0.
  - duty_applied=DUTY_MIN; compare=(DUTY_MIN*PERIOD)>>16; duty_ready=1.
- Counter:
  - While enable=1: cnt counts 0..PERIOD-1, then wraps to 0.
  - While enable=0: cnt is held at 0.
- Handshake:
  - duty_ready = !pending.
  - A transfer occurs on a clk edge with duty_valid && duty_ready.
  - On transfer: shadow <= clamp(duty_in, DUTY_MIN, DUTY_MAX); pending<=1; clamp_flag <= (duty_in was outside the range).
  - With pending=1, duty_valid is ignored; the master holds its data.
- Load at wrap (cycle with cnt==PERIOD-1 and enable=1), if pending:
  - duty_applied<=shadow; compare<=(shadow*PERIOD)>>16 (32-bit product, truncate to CNT_W); pending<=0.
  - A transfer on that same edge is not loaded until the next wrap.
- raw = (cnt < compare).
- Dead-time FSM, outputs registered:
  - IDLE: both outputs 0. Leaves to LO when enable rises.
  - LO: lo=1. Goes to DT_LH when raw=1.
  - DT_LH: both outputs 0, counts DEADTIME cycles. At the end goes to HI if raw=1, otherwise LO. If raw falls mid-count, returns to LO immediately.
  - HI: hi=1. Goes to DT_HL when raw=0.
  - DT_HL: both outputs 0, counts DEADTIME cycles. At the end goes to LO if raw=0, otherwise HI. If raw rises mid-count, returns to HI immediately.
  - Any state with enable=0 goes to IDLE on the next edge.
- Invariant: pwm_hi && pwm_lo is never 1.
- Strobes: period_start and sample_trig are registered one-cycle pulses, generated only while enable=1.
- enable fall mid-period: both outputs 0 next cycle; duty_applied and pending are retained.
- enable re-rise: cnt restarts at 0, period_start pulses, FSM enters LO.

Optional Feature:
- Macro: PWM_SOFTSTART_EN.
- Defined: at each wrap, duty_applied steps toward the target (latest loaded shadow) by at most RAMP_STEP.
  - Start point after reset or an enable rise is DUTY_MIN.
  - compare follows duty_applied.
  - pending clears when the shadow is consumed as the target.
- Undefined: the target is applied in one step at the wrap.

Decomposition:
- Package mppt_pkg holds:
  - DUTY_W=16, DUTY_MIN/DUTY_MAX defaults.
  - The dead-time FSM state enum (IDLE, LO, DT_LH, HI, DT_HL).
  - A clamp function.
- One sub-module, pwm_deadtime_fsm: takes raw, enable and DEADTIME and produces pwm_hi/pwm_lo.
- Counter, handshake and compare logic live in the top.

Test Plan:
- Duty 0x8000 (PERIOD=1000, DEADTIME=8): compare=500.
  - After the first wrap: pwm_hi high 492 cycles and pwm_lo high 492 cycles per period.
  - period_start every 1000 cycles; sample_trig at cnt=500.
- Clamping:
  - duty_in=0xFFFF: duty_applied=0xF333, compare=949, clamp_flag=1.
  - duty_in=0x0000: duty_applied=0x0CCD, compare=50, clamp_flag=1.
- Two commands, 0x4000 then 0xC000, in one period:
  - First is accepted; duty_ready=0 until the wrap; second is held.
  - Next period compare=250; the period after, compare=750.
- Drop enable while pwm_hi=1: both outputs 0 next cycle. Re-enable: cnt=0, period_start pulse, pwm_lo=1.
- Assert reset mid-period without a clock edge: outputs 0 immediately. Release: duty_applied=0x0CCD, duty_ready=1.
- Every scenario: assertion that pwm_hi&&pwm_lo never holds, and both outputs are 0 for ≥DEADTIME cycles at every transition.
